frame_max_tracker: RTL and testbench



---
 rtl/frame_max_pkg.sv | 29 ++
 rtl/max_cmp_update.sv | 49 ++++
 rtl/frame_max_tracker.sv | 164 ++++++++++++++++
 tb/tb_frame_max_tracker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_max_pkg.sv
// Shared definitions for the frame maximum tracker and related datapaths.
// Holds the default widths, the frame state encoding and an
// elaboration-time ceil(log2) helper used for parameter consistency checks.
package frame_max_pkg;

    localparam int DEF_SIG_WIDTH  = 10;
    localparam int DEF_FRAME_LEN  = 16;
    localparam int DEF_IDX_WIDTH  = 4;
    localparam int DEF_FCNT_WIDTH = 16;

    // Frame accumulation state: waiting for a frame's first sample, or accumulating.
    localparam logic [0:0] S_FIRST = 1'b0;
    localparam logic [0:0] S_ACC   = 1'b1;

    // ceil(log2(value)) for value >= 1; returns 0 for value == 1.
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (32'sd1 <<< i)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/max_cmp_update.sv
// Signed compare-and-select of a (value, index) pair.
// Returns the larger of the current best and a candidate; on equal values
// the lower index is kept, so the earliest occurrence of a maximum wins.
// Ports:
//   cur_max  / cur_idx  : current best value and its index
//   cand_val / cand_idx : candidate value and its index
//   new_max  / new_idx  : selected value and index
import frame_max_pkg::*;

module max_cmp_update #(
    parameter int SIG_WIDTH = DEF_SIG_WIDTH,
    parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
    input  logic signed [SIG_WIDTH-1:0] cur_max,
    input  logic        [IDX_WIDTH-1:0] cur_idx,
    input  logic signed [SIG_WIDTH-1:0] cand_val,
    input  logic        [IDX_WIDTH-1:0] cand_idx,
    output logic signed [SIG_WIDTH-1:0] new_max,
    output logic        [IDX_WIDTH-1:0] new_idx
);

    logic take_s;

    // Candidate wins on strictly greater value, or equal value at a lower index.
    always_comb begin
        take_s = 1'b0;
        if (cand_val > cur_max) begin
            take_s = 1'b1;
        end else if ((cand_val == cur_max) && (cand_idx < cur_idx)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Select the winning pair.
    always_comb begin
        new_max = cur_max;
        new_idx = cur_idx;
        if (take_s) begin
            new_max = cand_val;
            new_idx = cand_idx;
        end else begin
            new_max = cur_max;
            new_idx = cur_idx;
        end
    end

endmodule

// File: rtl/frame_max_tracker.sv
// Groups a signed sample stream into frames of FRAME_LEN samples and reports,
// per frame, the maximum value, its 0-based index within the frame and a
// wrapping frame number. Valid/ready on both sides; the result sits in a
// single-entry holding register. Only the sample that would complete a frame
// stalls while an older result is still unconsumed.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid, in_ready, in_data    : sample input handshake
//   out_valid, out_ready           : result handshake
//   out_max, out_idx, out_fnum     : frame maximum, its index, frame number
import frame_max_pkg::*;

module frame_max_tracker #(
    parameter int SIG_WIDTH  = DEF_SIG_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int FCNT_WIDTH = DEF_FCNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [SIG_WIDTH-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [SIG_WIDTH-1:0]  out_max,
    output logic        [IDX_WIDTH-1:0]  out_idx,
    output logic        [FCNT_WIDTH-1:0] out_fnum
);

    if (IDX_WIDTH != clog2_f(FRAME_LEN)) begin : g_idx_width_check
        $error("frame_max_tracker: IDX_WIDTH must equal clog2(FRAME_LEN)");
    end
    if ((FRAME_LEN < 2) || (FRAME_LEN > 256)) begin : g_frame_len_check
        $error("frame_max_tracker: FRAME_LEN must be in 2..256");
    end

    // Counter value carried by the sample that completes a frame.
    localparam logic [IDX_WIDTH-1:0] LAST_CNT = IDX_WIDTH'(FRAME_LEN - 1);

    logic [0:0]                  state_r;
    logic [IDX_WIDTH-1:0]        cnt_r;
    logic signed [SIG_WIDTH-1:0] max_r;
    logic [IDX_WIDTH-1:0]        best_idx_r;
    logic [FCNT_WIDTH-1:0]       fcnt_r;
    logic                        out_valid_r;
    logic signed [SIG_WIDTH-1:0] out_max_r;
    logic [IDX_WIDTH-1:0]        out_idx_r;
    logic [FCNT_WIDTH-1:0]       out_fnum_r;

    logic                        last_s;
    logic                        in_ready_s;
    logic                        in_xfer_s;
    logic                        out_xfer_s;
    logic                        frame_done_s;
    logic signed [SIG_WIDTH-1:0] upd_max_s;
    logic [IDX_WIDTH-1:0]        upd_idx_s;

    max_cmp_update #(
        .SIG_WIDTH (SIG_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_cmp (
        .cur_max  (max_r),
        .cur_idx  (best_idx_r),
        .cand_val (in_data),
        .cand_idx (cnt_r),
        .new_max  (upd_max_s),
        .new_idx  (upd_idx_s)
    );

    // Next accepted sample would complete the current frame.
    always_comb begin
        last_s = 1'b0;
        if ((state_r == S_ACC) && (cnt_r == LAST_CNT)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Stall only the completing sample while the result register is full and
    // not being drained this cycle; a drain in the same cycle frees the slot.
    always_comb begin
        in_ready_s = 1'b1;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (last_s && out_valid_r && !out_ready) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    // Handshake events for this cycle.
    always_comb begin
        in_xfer_s    = in_valid && in_ready_s;
        out_xfer_s   = out_valid_r && out_ready;
        frame_done_s = in_valid && in_ready_s && last_s;
    end

    // Running max, best index, sample counter and frame state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FIRST;
            cnt_r      <= {IDX_WIDTH{1'b0}};
            max_r      <= {SIG_WIDTH{1'b0}};
            best_idx_r <= {IDX_WIDTH{1'b0}};
        end else if (in_xfer_s) begin
            case (state_r)
                S_FIRST: begin
                    max_r      <= in_data;
                    best_idx_r <= {IDX_WIDTH{1'b0}};
                    cnt_r      <= IDX_WIDTH'(1);
                    state_r    <= S_ACC;
                end
                S_ACC: begin
                    if (last_s) begin
                        cnt_r   <= {IDX_WIDTH{1'b0}};
                        state_r <= S_FIRST;
                    end else begin
                        max_r      <= upd_max_s;
                        best_idx_r <= upd_idx_s;
                        cnt_r      <= cnt_r + IDX_WIDTH'(1);
                    end
                end
                default: begin
                    cnt_r   <= {IDX_WIDTH{1'b0}};
                    state_r <= S_FIRST;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Result holding register and frame counter; a load on frame completion
    // takes priority over a drain so back-to-back results leave no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_max_r   <= {SIG_WIDTH{1'b0}};
            out_idx_r   <= {IDX_WIDTH{1'b0}};
            out_fnum_r  <= {FCNT_WIDTH{1'b0}};
            fcnt_r      <= {FCNT_WIDTH{1'b0}};
        end else if (frame_done_s) begin
            out_valid_r <= 1'b1;
            out_max_r   <= upd_max_s;
            out_idx_r   <= upd_idx_s;
            out_fnum_r  <= fcnt_r;
            fcnt_r      <= fcnt_r + FCNT_WIDTH'(1);
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_max   = out_max_r;
    assign out_idx   = out_idx_r;
    assign out_fnum  = out_fnum_r;

endmodule

// File: tb/tb_frame_max_tracker.sv
// Self-checking bench for frame_max_tracker: a table of known frames, directed
// backpressure / reset / counter-wrap sequences, and randomized traffic
// checked against a frame-level reference model.
module tb_frame_max_tracker;

    localparam int SW = 10;
    localparam int FL = 16;
    localparam int IW = 4;
    localparam int FW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [SW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [SW-1:0] out_max;
    logic [IW-1:0]        out_idx;
    logic [FW-1:0]        out_fnum;

    logic                 in_ready2;
    logic                 out_valid2;
    logic signed [SW-1:0] out_max2;
    logic [IW-1:0]        out_idx2;
    logic [1:0]           out_fnum2;

    frame_max_tracker #(.SIG_WIDTH(SW), .FRAME_LEN(FL), .IDX_WIDTH(IW), .FCNT_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
        .out_fnum(out_fnum)
    );

    // Narrow frame counter copy, fed identically, for the wrap check.
    frame_max_tracker #(.SIG_WIDTH(SW), .FRAME_LEN(FL), .IDX_WIDTH(IW), .FCNT_WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_max(out_max2), .out_idx(out_idx2),
        .out_fnum(out_fnum2)
    );

    always #5 clk = ~clk;

    typedef struct { int mx; int ix; int fn; } res_t;
    typedef struct { logic [FL-1:0][SW-1:0] s; int mx; int ix; } vec_t;

    res_t exp_q[$];
    res_t popped[$];
    int   fbuf[$];
    int   fcount;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[4];
    int   wrap_exp[5] = '{0, 1, 2, 3, 0};
    int   gs[3*FL];
    logic took;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        fbuf.delete();
        fcount = 0;
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic v, input int d, input logic rdy, output logic tk);
        res_t r;
        res_t o;
        logic er;
        in_valid  = v;
        in_data   = SW'(d);
        out_ready = rdy;
        #1;
        er = !((fbuf.size() == FL - 1) && (exp_q.size() != 0) && !rdy);
        chk("in_ready", int'(in_ready), int'(er));
        chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        chk("out_valid_w2", int'(out_valid2), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_max", int'(out_max), exp_q[0].mx);
            chk("out_idx", int'(out_idx), exp_q[0].ix);
            chk("out_fnum", int'(out_fnum), exp_q[0].fn);
            chk("out_fnum_w2", int'(out_fnum2), exp_q[0].fn % 4);
        end
        tk = v && er;
        if (rdy && exp_q.size() != 0) begin
            o.mx = int'(out_max);
            o.ix = int'(out_idx);
            o.fn = int'(out_fnum);
            popped.push_back(o);
            r = exp_q.pop_front();
        end
        if (tk) begin
            fbuf.push_back(d);
            if (fbuf.size() == FL) begin
                r.mx = fbuf[0];
                r.ix = 0;
                for (int i = 1; i < FL; i++) begin
                    if (fbuf[i] > r.mx) begin
                        r.mx = fbuf[i];
                        r.ix = i;
                    end
                end
                r.fn = fcount % 65536;
                fcount++;
                exp_q.push_back(r);
                fbuf.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_max", int'(out_max), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_fnum", int'(out_fnum), 0);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(1023, 0)) - 512;
    endfunction

    task automatic feed_random_frame(input logic rdy);
        logic t;
        for (int i = 0; i < FL; i++) begin
            step(1'b1, rnd_sample(), rdy, t);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Table of frames with hand-derived results.
        for (int i = 0; i < FL; i++) begin
            tbl[0].s[i] = SW'(i);
            tbl[1].s[i] = SW'(-1);
            tbl[2].s[i] = SW'(-512);
            tbl[3].s[i] = SW'(i * 3 - 40);
        end
        tbl[0].mx = 15;   tbl[0].ix = 15;
        tbl[1].s[0] = SW'(-5); tbl[1].s[1] = SW'(-512); tbl[1].s[2] = SW'(7);
        tbl[1].s[3] = SW'(3);  tbl[1].s[4] = SW'(7);
        tbl[1].mx = 7;    tbl[1].ix = 2;
        tbl[2].mx = -512; tbl[2].ix = 0;
        tbl[3].s[9] = SW'(200); tbl[3].s[12] = SW'(200);
        tbl[3].mx = 200;  tbl[3].ix = 9;

        do_reset();

        // Table-driven frames, back-to-back, downstream always ready.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < FL; i++) begin
                step(1'b1, int'($signed(tbl[k].s[i])), 1'b1, took);
            end
            chk("tbl_valid", int'(out_valid), 1);
            chk("tbl_max", int'(out_max), tbl[k].mx);
            chk("tbl_idx", int'(out_idx), tbl[k].ix);
            chk("tbl_fnum", int'(out_fnum), k);
        end
        step(1'b0, 0, 1'b1, took);
        chk("tbl_drained", int'(out_valid), 0);

        // Backpressure: result 0 waits while frame 1 streams; only sample 15 stalls.
        do_reset();
        feed_random_frame(1'b1);
        for (int i = 0; i < FL - 1; i++) begin
            step(1'b1, rnd_sample(), 1'b0, took);
        end
        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'b1;
            in_data   = SW'(100);
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_fnum", int'(out_fnum), 0);
            chk("bp_hold_max", int'(out_max), exp_q[0].mx);
            @(negedge clk);
        end
        step(1'b1, 100, 1'b1, took);
        chk("bp_nobubble_valid", int'(out_valid), 1);
        chk("bp_nobubble_fnum", int'(out_fnum), 1);
        step(1'b0, 0, 1'b1, took);

        // Reset mid-frame with a pending result, then a fresh frame.
        do_reset();
        feed_random_frame(1'b1);
        feed_random_frame(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rnd_sample(), 1'b0, took);
        end
        do_reset();
        for (int i = 0; i < FL; i++) begin
            step(1'b1, (i == 5) ? 450 : (i - 30), 1'b1, took);
        end
        chk("rstmid_valid", int'(out_valid), 1);
        chk("rstmid_fnum", int'(out_fnum), 0);
        chk("rstmid_max", int'(out_max), 450);
        chk("rstmid_idx", int'(out_idx), 5);
        step(1'b0, 0, 1'b1, took);

        // Frame counter wrap on the 2-bit copy.
        do_reset();
        for (int f = 0; f < 5; f++) begin
            feed_random_frame(1'b1);
            chk("wrap_valid", int'(out_valid2), 1);
            chk("wrap_fnum", int'(out_fnum2), wrap_exp[f]);
        end
        step(1'b0, 0, 1'b1, took);

        // Gapped input: three frames with the maximum planted at index 9.
        do_reset();
        popped.delete();
        for (int i = 0; i < 3 * FL; i++) begin
            gs[i] = ((i % FL) == 9) ? 300 : (int'($urandom_range(811, 0)) - 512);
        end
        begin
            int acc = 0;
            int cyc = 0;
            while (acc < 3 * FL && cyc < 2000) begin
                step(1'b1 & $urandom_range(1, 0), gs[acc % (3 * FL)],
                     ($urandom_range(9, 0) < 7), took);
                if (took) acc++;
                cyc++;
            end
            if (acc < 3 * FL) begin
                chk("gap_timeout", acc, 3 * FL);
            end
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 20) begin
                step(1'b0, 0, 1'b1, took);
                cyc++;
            end
        end
        chk("gap_count", popped.size(), 3);
        for (int k = 0; k < 3 && k < popped.size(); k++) begin
            chk("gap_max", popped[k].mx, 300);
            chk("gap_idx", popped[k].ix, 9);
            chk("gap_fnum", popped[k].fn, k);
        end

        // Random traffic with random gaps and backpressure.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(3, 0) != 0), rnd_sample(), ($urandom_range(3, 0) != 0), took);
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 0, 1'b1, took);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
